// File: rtl/memory_access_stage.sv
// memory_access_stage
//   MEM pipeline stage sitting directly upstream of write-back. Takes the EX
//   result, runs loads/stores against the data cache over a req/ready
//   handshake, aligns and extends load data, and registers the MEM/WB slot
//   that feeds the write-back mux. Upstream is stalled while a cache access
//   is outstanding.
//
// Ports
//   CLK, RST                   clock (rising edge), async active-high reset
//   VALID_IN .. WRITE_BACK_MUX_SELECT_IN
//                              EX/MEM instruction: result/address, store data,
//                              load/store, funct3, rd, reg-write, wb select
//   STALL_OUT                  upstream must hold its inputs this cycle
//   DCACHE_REQ/WE/ADDR/WDATA/BYTE_EN
//                              registered cache request, held until READY
//   DCACHE_READY, DCACHE_RDATA access completes this cycle / load word
//   VALID_OUT .. REG_WRITE_OUT MEM/WB slot towards write-back
//   MISALIGNED_OUT             1-cycle flag: access dropped as misaligned
//
// HIGH is the active level of the control inputs.
// Only DATA_WIDTH = 32 (four byte lanes) is supported.
module memory_access_stage #(
  parameter int   DATA_WIDTH     = 32,
  parameter int   REG_ADDR_WIDTH = 5,
  parameter logic HIGH           = 1'b1
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      VALID_IN,
  input  logic [DATA_WIDTH-1:0]     ALU_OUT_IN,
  input  logic [DATA_WIDTH-1:0]     RS2_DATA_IN,
  input  logic                      MEM_READ_IN,
  input  logic                      MEM_WRITE_IN,
  input  logic [2:0]                FUNCT3_IN,
  input  logic [REG_ADDR_WIDTH-1:0] RD_ADDR_IN,
  input  logic                      REG_WRITE_IN,
  input  logic                      WRITE_BACK_MUX_SELECT_IN,
  output logic                      STALL_OUT,
  output logic                      DCACHE_REQ,
  output logic                      DCACHE_WE,
  output logic [DATA_WIDTH-1:0]     DCACHE_ADDR,
  output logic [DATA_WIDTH-1:0]     DCACHE_WDATA,
  output logic [3:0]                DCACHE_BYTE_EN,
  input  logic                      DCACHE_READY,
  input  logic [DATA_WIDTH-1:0]     DCACHE_RDATA,
  output logic                      VALID_OUT,
  output logic [DATA_WIDTH-1:0]     ALU_OUT_OUT,
  output logic [DATA_WIDTH-1:0]     DATA_CACHE_OUT_DATA,
  output logic                      WRITE_BACK_MUX_SELECT_OUT,
  output logic [REG_ADDR_WIDTH-1:0] RD_ADDR_OUT,
  output logic                      REG_WRITE_OUT,
  output logic                      MISALIGNED_OUT
);

  typedef enum logic [0:0] {IDLE = 1'b0, ACCESS = 1'b1} state_t;

  // Map funct3 onto a supported access width; anything undefined behaves as W.
  // BU/HU have no store meaning, so a store with those codes is a word store.
  function automatic logic [2:0] eff_funct3(input logic [2:0] f3, input logic is_store);
    logic [2:0] r;
    case (f3)
      3'b000, 3'b001, 3'b010: r = f3;
      3'b100, 3'b101:         r = is_store ? 3'b010 : f3;
      default:                r = 3'b010;
    endcase
    return r;
  endfunction

  function automatic logic is_aligned(input logic [1:0] offset, input logic [2:0] f3);
    logic ok;
    case (f3)
      3'b000, 3'b100: ok = 1'b1;
      3'b001, 3'b101: ok = (offset[0] == 1'b0);
      default:        ok = (offset == 2'b00);
    endcase
    return ok;
  endfunction

  function automatic logic [3:0] store_byte_en(input logic [1:0] offset, input logic [2:0] f3);
    logic [3:0] be;
    case (f3)
      3'b000:  be = 4'b0001 << offset;
      3'b001:  be = 4'b0011 << offset;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Data is replicated on every lane; BYTE_EN picks the lanes actually written.
  function automatic logic [31:0] store_wdata(input logic [31:0] rs2, input logic [2:0] f3);
    logic [31:0] wd;
    case (f3)
      3'b000:  wd = {4{rs2[7:0]}};
      3'b001:  wd = {2{rs2[15:0]}};
      default: wd = rs2;
    endcase
    return wd;
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] rdata, input logic [1:0] offset,
                                               input logic [2:0] f3);
    logic [31:0] sh;
    logic [31:0] ld;
    sh = rdata >> {offset, 3'b000};
    case (f3)
      3'b000:  ld = {{24{sh[7]}}, sh[7:0]};
      3'b100:  ld = {24'd0, sh[7:0]};
      3'b001:  ld = {{16{sh[15]}}, sh[15:0]};
      3'b101:  ld = {16'd0, sh[15:0]};
      default: ld = rdata;
    endcase
    return ld;
  endfunction

  state_t                    state_r, state_nxt_s;
  logic                      hold_r, hold_nxt_s;
  // Operation latched at accept: the access in flight, or an op parked in hold.
  logic [DATA_WIDTH-1:0]     op_addr_r, op_addr_nxt_s;
  logic [2:0]                op_f3_r, op_f3_nxt_s;
  logic [REG_ADDR_WIDTH-1:0] op_rd_r, op_rd_nxt_s;
  logic                      op_read_r, op_read_nxt_s;
  logic                      op_write_r, op_write_nxt_s;
  logic                      op_reg_write_r, op_reg_write_nxt_s;
  logic                      op_wb_sel_r, op_wb_sel_nxt_s;
  logic                      op_mis_r, op_mis_nxt_s;
  // Cache request registers.
  logic                      req_r, req_nxt_s, we_r, we_nxt_s;
  logic [DATA_WIDTH-1:0]     addr_r, addr_nxt_s, wdata_r, wdata_nxt_s;
  logic [3:0]                be_r, be_nxt_s;
  // MEM/WB slot.
  logic                      valid_r, valid_nxt_s, wb_sel_r, wb_sel_nxt_s;
  logic                      reg_write_r, reg_write_nxt_s, mis_r, mis_nxt_s;
  logic [DATA_WIDTH-1:0]     alu_r, alu_nxt_s, data_r, data_nxt_s;
  logic [REG_ADDR_WIDTH-1:0] rd_r, rd_nxt_s;

  logic       in_valid_s, in_read_s, in_write_s, in_reg_write_s, ready_s;
  logic [2:0] in_f3_s;
  logic       in_mem_s, in_access_s, in_mis_s, in_done_s;
  logic       complete_s, accept_s, start_s;

  assign in_valid_s     = (VALID_IN == HIGH);
  assign in_read_s      = (MEM_READ_IN == HIGH);
  assign in_write_s     = (MEM_WRITE_IN == HIGH);
  assign in_reg_write_s = (REG_WRITE_IN == HIGH);
  assign ready_s        = (DCACHE_READY == HIGH);
  assign in_f3_s        = eff_funct3(FUNCT3_IN, in_write_s);
  assign in_mem_s       = in_valid_s & (in_read_s | in_write_s);
  assign in_access_s    = in_mem_s & is_aligned(ALU_OUT_IN[1:0], in_f3_s);
  assign in_mis_s       = in_mem_s & ~is_aligned(ALU_OUT_IN[1:0], in_f3_s);
  // A valid op that needs the MEM/WB slot without going to the cache.
  assign in_done_s      = in_valid_s & ~in_access_s;

  assign complete_s = (state_r == ACCESS) & ready_s;
  // While an op is parked in hold the slot is busy, so nothing new is taken.
  assign accept_s   = ((state_r == IDLE) & ~hold_r) | complete_s;
  assign start_s    = accept_s & in_access_s;
  assign STALL_OUT  = ((state_r == ACCESS) & ~ready_s) | hold_r;

  // Next-state, cache request and MEM/WB slot selection.
  always_comb begin
    state_nxt_s        = state_r;
    hold_nxt_s         = complete_s & in_done_s;
    op_addr_nxt_s      = op_addr_r;
    op_f3_nxt_s        = op_f3_r;
    op_rd_nxt_s        = op_rd_r;
    op_read_nxt_s      = op_read_r;
    op_write_nxt_s     = op_write_r;
    op_reg_write_nxt_s = op_reg_write_r;
    op_wb_sel_nxt_s    = op_wb_sel_r;
    op_mis_nxt_s       = op_mis_r;
    req_nxt_s          = req_r;
    we_nxt_s           = we_r;
    addr_nxt_s         = addr_r;
    wdata_nxt_s        = wdata_r;
    be_nxt_s           = be_r;
    valid_nxt_s        = 1'b0;
    reg_write_nxt_s    = 1'b0;
    mis_nxt_s          = 1'b0;
    alu_nxt_s          = alu_r;
    data_nxt_s         = data_r;
    wb_sel_nxt_s       = wb_sel_r;
    rd_nxt_s           = rd_r;

    if (accept_s) begin
      op_addr_nxt_s      = ALU_OUT_IN;
      op_f3_nxt_s        = in_f3_s;
      op_rd_nxt_s        = RD_ADDR_IN;
      op_read_nxt_s      = in_read_s;
      op_write_nxt_s     = in_write_s;
      op_reg_write_nxt_s = in_reg_write_s;
      op_wb_sel_nxt_s    = WRITE_BACK_MUX_SELECT_IN;
      op_mis_nxt_s       = in_mis_s;
    end else begin
      op_mis_nxt_s       = op_mis_r;
    end

    if (start_s) begin
      state_nxt_s = ACCESS;
      req_nxt_s   = 1'b1;
      we_nxt_s    = in_write_s;
      addr_nxt_s  = {ALU_OUT_IN[DATA_WIDTH-1:2], 2'b00};
      wdata_nxt_s = in_write_s ? store_wdata(RS2_DATA_IN, in_f3_s) : {DATA_WIDTH{1'b0}};
      be_nxt_s    = in_write_s ? store_byte_en(ALU_OUT_IN[1:0], in_f3_s) : 4'b0000;
    end else if (complete_s) begin
      state_nxt_s = IDLE;
      req_nxt_s   = 1'b0;
      we_nxt_s    = 1'b0;
    end else begin
      state_nxt_s = state_r;
    end

    if (hold_r) begin
      // Drain the op that arrived in the same cycle a cache access completed.
      valid_nxt_s     = 1'b1;
      alu_nxt_s       = op_addr_r;
      data_nxt_s      = {DATA_WIDTH{1'b0}};
      wb_sel_nxt_s    = op_wb_sel_r;
      rd_nxt_s        = op_rd_r;
      reg_write_nxt_s = op_reg_write_r & ~op_mis_r;
      mis_nxt_s       = op_mis_r;
    end else if (complete_s) begin
      valid_nxt_s     = 1'b1;
      alu_nxt_s       = op_addr_r;
      data_nxt_s      = op_read_r ? load_extract(DCACHE_RDATA, op_addr_r[1:0], op_f3_r)
                                  : {DATA_WIDTH{1'b0}};
      wb_sel_nxt_s    = op_read_r | op_wb_sel_r;
      rd_nxt_s        = op_rd_r;
      reg_write_nxt_s = op_reg_write_r & ~op_write_r;
    end else if ((state_r == IDLE) && !in_access_s) begin
      valid_nxt_s     = in_valid_s;
      alu_nxt_s       = ALU_OUT_IN;
      data_nxt_s      = {DATA_WIDTH{1'b0}};
      wb_sel_nxt_s    = WRITE_BACK_MUX_SELECT_IN;
      rd_nxt_s        = RD_ADDR_IN;
      reg_write_nxt_s = in_valid_s & in_reg_write_s & ~in_mis_s;
      mis_nxt_s       = in_mis_s;
    end else begin
      // Access starting or outstanding: the slot carries a bubble.
      valid_nxt_s     = 1'b0;
    end
  end

  // State and pipeline registers; reset abandons any in-flight access.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r        <= IDLE;
      hold_r         <= 1'b0;
      op_addr_r      <= {DATA_WIDTH{1'b0}};
      op_f3_r        <= 3'b000;
      op_rd_r        <= {REG_ADDR_WIDTH{1'b0}};
      op_read_r      <= 1'b0;
      op_write_r     <= 1'b0;
      op_reg_write_r <= 1'b0;
      op_wb_sel_r    <= 1'b0;
      op_mis_r       <= 1'b0;
      req_r          <= 1'b0;
      we_r           <= 1'b0;
      addr_r         <= {DATA_WIDTH{1'b0}};
      wdata_r        <= {DATA_WIDTH{1'b0}};
      be_r           <= 4'b0000;
      valid_r        <= 1'b0;
      alu_r          <= {DATA_WIDTH{1'b0}};
      data_r         <= {DATA_WIDTH{1'b0}};
      wb_sel_r       <= 1'b0;
      rd_r           <= {REG_ADDR_WIDTH{1'b0}};
      reg_write_r    <= 1'b0;
      mis_r          <= 1'b0;
    end else begin
      state_r        <= state_nxt_s;
      hold_r         <= hold_nxt_s;
      op_addr_r      <= op_addr_nxt_s;
      op_f3_r        <= op_f3_nxt_s;
      op_rd_r        <= op_rd_nxt_s;
      op_read_r      <= op_read_nxt_s;
      op_write_r     <= op_write_nxt_s;
      op_reg_write_r <= op_reg_write_nxt_s;
      op_wb_sel_r    <= op_wb_sel_nxt_s;
      op_mis_r       <= op_mis_nxt_s;
      req_r          <= req_nxt_s;
      we_r           <= we_nxt_s;
      addr_r         <= addr_nxt_s;
      wdata_r        <= wdata_nxt_s;
      be_r           <= be_nxt_s;
      valid_r        <= valid_nxt_s;
      alu_r          <= alu_nxt_s;
      data_r         <= data_nxt_s;
      wb_sel_r       <= wb_sel_nxt_s;
      rd_r           <= rd_nxt_s;
      reg_write_r    <= reg_write_nxt_s;
      mis_r          <= mis_nxt_s;
    end
  end

  assign DCACHE_REQ                = req_r;
  assign DCACHE_WE                 = we_r;
  assign DCACHE_ADDR               = addr_r;
  assign DCACHE_WDATA              = wdata_r;
  assign DCACHE_BYTE_EN            = be_r;
  assign VALID_OUT                 = valid_r;
  assign ALU_OUT_OUT               = alu_r;
  assign DATA_CACHE_OUT_DATA       = data_r;
  assign WRITE_BACK_MUX_SELECT_OUT = wb_sel_r;
  assign RD_ADDR_OUT               = rd_r;
  assign REG_WRITE_OUT             = reg_write_r;
  assign MISALIGNED_OUT            = mis_r;

endmodule

// File: tb/tb_memory_access_stage.sv
// Directed testbench for memory_access_stage.
module tb_memory_access_stage;

  logic        CLK = 1'b0;
  logic        RST;
  logic        VALID_IN;
  logic [31:0] ALU_OUT_IN, RS2_DATA_IN;
  logic        MEM_READ_IN, MEM_WRITE_IN;
  logic [2:0]  FUNCT3_IN;
  logic [4:0]  RD_ADDR_IN;
  logic        REG_WRITE_IN, WRITE_BACK_MUX_SELECT_IN;
  logic        STALL_OUT, DCACHE_REQ, DCACHE_WE;
  logic [31:0] DCACHE_ADDR, DCACHE_WDATA;
  logic [3:0]  DCACHE_BYTE_EN;
  logic        DCACHE_READY;
  logic [31:0] DCACHE_RDATA;
  logic        VALID_OUT;
  logic [31:0] ALU_OUT_OUT, DATA_CACHE_OUT_DATA;
  logic        WRITE_BACK_MUX_SELECT_OUT;
  logic [4:0]  RD_ADDR_OUT;
  logic        REG_WRITE_OUT, MISALIGNED_OUT;

  int total = 0;
  int bad   = 0;

  memory_access_stage dut (
    .CLK(CLK), .RST(RST), .VALID_IN(VALID_IN), .ALU_OUT_IN(ALU_OUT_IN),
    .RS2_DATA_IN(RS2_DATA_IN), .MEM_READ_IN(MEM_READ_IN), .MEM_WRITE_IN(MEM_WRITE_IN),
    .FUNCT3_IN(FUNCT3_IN), .RD_ADDR_IN(RD_ADDR_IN), .REG_WRITE_IN(REG_WRITE_IN),
    .WRITE_BACK_MUX_SELECT_IN(WRITE_BACK_MUX_SELECT_IN), .STALL_OUT(STALL_OUT),
    .DCACHE_REQ(DCACHE_REQ), .DCACHE_WE(DCACHE_WE), .DCACHE_ADDR(DCACHE_ADDR),
    .DCACHE_WDATA(DCACHE_WDATA), .DCACHE_BYTE_EN(DCACHE_BYTE_EN),
    .DCACHE_READY(DCACHE_READY), .DCACHE_RDATA(DCACHE_RDATA), .VALID_OUT(VALID_OUT),
    .ALU_OUT_OUT(ALU_OUT_OUT), .DATA_CACHE_OUT_DATA(DATA_CACHE_OUT_DATA),
    .WRITE_BACK_MUX_SELECT_OUT(WRITE_BACK_MUX_SELECT_OUT), .RD_ADDR_OUT(RD_ADDR_OUT),
    .REG_WRITE_OUT(REG_WRITE_OUT), .MISALIGNED_OUT(MISALIGNED_OUT)
  );

  always #5 CLK = ~CLK;

  task automatic drive_idle();
    VALID_IN = 1'b0; ALU_OUT_IN = 32'h0; RS2_DATA_IN = 32'h0;
    MEM_READ_IN = 1'b0; MEM_WRITE_IN = 1'b0; FUNCT3_IN = 3'b000;
    RD_ADDR_IN = 5'd0; REG_WRITE_IN = 1'b0; WRITE_BACK_MUX_SELECT_IN = 1'b0;
  endtask

  task automatic set_op(input logic [31:0] a, input logic [31:0] r2, input logic [4:0] rd,
                        input logic [2:0] f3, input logic rd_en, input logic wr_en,
                        input logic rw, input logic wb);
    VALID_IN = 1'b1; ALU_OUT_IN = a; RS2_DATA_IN = r2; RD_ADDR_IN = rd; FUNCT3_IN = f3;
    MEM_READ_IN = rd_en; MEM_WRITE_IN = wr_en; REG_WRITE_IN = rw;
    WRITE_BACK_MUX_SELECT_IN = wb;
  endtask

  task automatic test_reset();
    RST = 1'b1; drive_idle(); DCACHE_READY = 1'b0; DCACHE_RDATA = 32'h0;
    repeat (3) @(posedge CLK);
    #1;
    total++; if (VALID_OUT !== 1'b0) begin bad++; $display("FAIL rst_valid got=%0h want=0", VALID_OUT); end
    total++; if (DCACHE_REQ !== 1'b0) begin bad++; $display("FAIL rst_req got=%0h want=0", DCACHE_REQ); end
    total++; if (REG_WRITE_OUT !== 1'b0) begin bad++; $display("FAIL rst_regw got=%0h want=0", REG_WRITE_OUT); end
    total++; if (MISALIGNED_OUT !== 1'b0) begin bad++; $display("FAIL rst_mis got=%0h want=0", MISALIGNED_OUT); end
    total++; if (ALU_OUT_OUT !== 32'h0) begin bad++; $display("FAIL rst_alu got=%0h want=0", ALU_OUT_OUT); end
    total++; if (DATA_CACHE_OUT_DATA !== 32'h0) begin bad++; $display("FAIL rst_data got=%0h want=0", DATA_CACHE_OUT_DATA); end
    total++; if (STALL_OUT !== 1'b0) begin bad++; $display("FAIL rst_stall got=%0h want=0", STALL_OUT); end
    RST = 1'b0;
  endtask

  task automatic test_alu();
    set_op(32'h0000_1234, 32'h0, 5'd5, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0);
    #1;
    total++; if (STALL_OUT !== 1'b0) begin bad++; $display("FAIL alu_stall0 got=%0h want=0", STALL_OUT); end
    @(posedge CLK); #1;
    total++; if (VALID_OUT !== 1'b1) begin bad++; $display("FAIL alu_valid got=%0h want=1", VALID_OUT); end
    total++; if (ALU_OUT_OUT !== 32'h1234) begin bad++; $display("FAIL alu_out got=%0h want=1234", ALU_OUT_OUT); end
    total++; if (RD_ADDR_OUT !== 5'd5) begin bad++; $display("FAIL alu_rd got=%0h want=5", RD_ADDR_OUT); end
    total++; if (REG_WRITE_OUT !== 1'b1) begin bad++; $display("FAIL alu_regw got=%0h want=1", REG_WRITE_OUT); end
    total++; if (WRITE_BACK_MUX_SELECT_OUT !== 1'b0) begin bad++; $display("FAIL alu_wbsel got=%0h want=0", WRITE_BACK_MUX_SELECT_OUT); end
    total++; if (DCACHE_REQ !== 1'b0) begin bad++; $display("FAIL alu_req got=%0h want=0", DCACHE_REQ); end
    total++; if (STALL_OUT !== 1'b0) begin bad++; $display("FAIL alu_stall1 got=%0h want=0", STALL_OUT); end
    drive_idle();
    @(posedge CLK); #1;
    total++; if (VALID_OUT !== 1'b0) begin bad++; $display("FAIL alu_bubble_valid got=%0h want=0", VALID_OUT); end
    total++; if (REG_WRITE_OUT !== 1'b0) begin bad++; $display("FAIL alu_bubble_regw got=%0h want=0", REG_WRITE_OUT); end
  endtask

  // Loads with READY arriving on the third access cycle.
  task automatic test_load();
    logic [31:0] addr_t [3];
    logic [2:0]  f3_t   [3];
    logic [31:0] rdat_t [3];
    logic [31:0] exp_t  [3];
    addr_t = '{32'h0000_0103, 32'h0000_0103, 32'h0000_0102};
    f3_t   = '{3'b000, 3'b100, 3'b101};
    rdat_t = '{32'h80FF_0000, 32'h80FF_0000, 32'h8001_0000};
    exp_t  = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_8001};
    for (int i = 0; i < 3; i++) begin
      int stalls;
      stalls = 0;
      set_op(addr_t[i], 32'h0, 5'd7, f3_t[i], 1'b1, 1'b0, 1'b1, 1'b1);
      DCACHE_READY = 1'b0; DCACHE_RDATA = rdat_t[i];
      @(posedge CLK); #1;
      drive_idle();
      total++; if (DCACHE_REQ !== 1'b1) begin bad++; $display("FAIL ld%0d_req got=%0h want=1", i, DCACHE_REQ); end
      total++; if (DCACHE_ADDR !== (addr_t[i] & 32'hFFFF_FFFC)) begin bad++; $display("FAIL ld%0d_addr got=%0h want=%0h", i, DCACHE_ADDR, addr_t[i] & 32'hFFFF_FFFC); end
      total++; if (DCACHE_WE !== 1'b0) begin bad++; $display("FAIL ld%0d_we got=%0h want=0", i, DCACHE_WE); end
      total++; if (VALID_OUT !== 1'b0) begin bad++; $display("FAIL ld%0d_bubble got=%0h want=0", i, VALID_OUT); end
      if (STALL_OUT === 1'b1) stalls++;
      @(posedge CLK); #1;
      if (STALL_OUT === 1'b1) stalls++;
      @(posedge CLK); #1;
      DCACHE_READY = 1'b1; #1;
      if (STALL_OUT === 1'b1) stalls++;
      total++; if (stalls != 2) begin bad++; $display("FAIL ld%0d_stall_cycles got=%0d want=2", i, stalls); end
      total++; if (DCACHE_REQ !== 1'b1) begin bad++; $display("FAIL ld%0d_req_hold got=%0h want=1", i, DCACHE_REQ); end
      @(posedge CLK); #1;
      DCACHE_READY = 1'b0;
      total++; if (VALID_OUT !== 1'b1) begin bad++; $display("FAIL ld%0d_valid got=%0h want=1", i, VALID_OUT); end
      total++; if (DATA_CACHE_OUT_DATA !== exp_t[i]) begin bad++; $display("FAIL ld%0d_data got=%0h want=%0h", i, DATA_CACHE_OUT_DATA, exp_t[i]); end
      total++; if (ALU_OUT_OUT !== addr_t[i]) begin bad++; $display("FAIL ld%0d_alu got=%0h want=%0h", i, ALU_OUT_OUT, addr_t[i]); end
      total++; if (REG_WRITE_OUT !== 1'b1) begin bad++; $display("FAIL ld%0d_regw got=%0h want=1", i, REG_WRITE_OUT); end
      total++; if (WRITE_BACK_MUX_SELECT_OUT !== 1'b1) begin bad++; $display("FAIL ld%0d_wbsel got=%0h want=1", i, WRITE_BACK_MUX_SELECT_OUT); end
      total++; if (RD_ADDR_OUT !== 5'd7) begin bad++; $display("FAIL ld%0d_rd got=%0h want=7", i, RD_ADDR_OUT); end
      total++; if (DCACHE_REQ !== 1'b0) begin bad++; $display("FAIL ld%0d_req_drop got=%0h want=0", i, DCACHE_REQ); end
    end
  endtask

  // Stores at minimum latency (READY on the first access cycle).
  task automatic test_store();
    logic [31:0] addr_t [3];
    logic [2:0]  f3_t   [3];
    logic [31:0] rs2_t  [3];
    logic [3:0]  be_t   [3];
    logic [31:0] wd_t   [3];
    addr_t = '{32'h0000_0202, 32'h0000_0201, 32'h0000_0300};
    f3_t   = '{3'b001, 3'b000, 3'b010};
    rs2_t  = '{32'h1234_ABCD, 32'h0000_005A, 32'hDEAD_BEEF};
    be_t   = '{4'b1100, 4'b0010, 4'b1111};
    wd_t   = '{32'hABCD_ABCD, 32'h5A5A_5A5A, 32'hDEAD_BEEF};
    for (int i = 0; i < 3; i++) begin
      set_op(addr_t[i], rs2_t[i], 5'd9, f3_t[i], 1'b0, 1'b1, 1'b1, 1'b0);
      DCACHE_READY = 1'b1;
      @(posedge CLK); #1;
      drive_idle();
      total++; if (DCACHE_REQ !== 1'b1) begin bad++; $display("FAIL st%0d_req got=%0h want=1", i, DCACHE_REQ); end
      total++; if (DCACHE_WE !== 1'b1) begin bad++; $display("FAIL st%0d_we got=%0h want=1", i, DCACHE_WE); end
      total++; if (DCACHE_BYTE_EN !== be_t[i]) begin bad++; $display("FAIL st%0d_be got=%0b want=%0b", i, DCACHE_BYTE_EN, be_t[i]); end
      total++; if (DCACHE_WDATA !== wd_t[i]) begin bad++; $display("FAIL st%0d_wdata got=%0h want=%0h", i, DCACHE_WDATA, wd_t[i]); end
      total++; if (DCACHE_ADDR !== (addr_t[i] & 32'hFFFF_FFFC)) begin bad++; $display("FAIL st%0d_addr got=%0h want=%0h", i, DCACHE_ADDR, addr_t[i] & 32'hFFFF_FFFC); end
      total++; if (STALL_OUT !== 1'b0) begin bad++; $display("FAIL st%0d_stall got=%0h want=0", i, STALL_OUT); end
      @(posedge CLK); #1;
      DCACHE_READY = 1'b0;
      total++; if (VALID_OUT !== 1'b1) begin bad++; $display("FAIL st%0d_valid got=%0h want=1", i, VALID_OUT); end
      total++; if (REG_WRITE_OUT !== 1'b0) begin bad++; $display("FAIL st%0d_regw got=%0h want=0", i, REG_WRITE_OUT); end
      total++; if (DCACHE_REQ !== 1'b0) begin bad++; $display("FAIL st%0d_req_drop got=%0h want=0", i, DCACHE_REQ); end
    end
  endtask

  task automatic test_misaligned();
    logic [31:0] addr_t [3];
    logic [2:0]  f3_t   [3];
    logic        wr_t   [3];
    addr_t = '{32'h0000_0302, 32'h0000_0101, 32'h0000_0206};
    f3_t   = '{3'b010, 3'b001, 3'b010};
    wr_t   = '{1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      set_op(addr_t[i], 32'h0, 5'd3, f3_t[i], ~wr_t[i], wr_t[i], 1'b1, ~wr_t[i]);
      DCACHE_READY = 1'b0;
      @(posedge CLK); #1;
      drive_idle();
      total++; if (DCACHE_REQ !== 1'b0) begin bad++; $display("FAIL mis%0d_req got=%0h want=0", i, DCACHE_REQ); end
      total++; if (MISALIGNED_OUT !== 1'b1) begin bad++; $display("FAIL mis%0d_flag got=%0h want=1", i, MISALIGNED_OUT); end
      total++; if (VALID_OUT !== 1'b1) begin bad++; $display("FAIL mis%0d_valid got=%0h want=1", i, VALID_OUT); end
      total++; if (REG_WRITE_OUT !== 1'b0) begin bad++; $display("FAIL mis%0d_regw got=%0h want=0", i, REG_WRITE_OUT); end
      total++; if (ALU_OUT_OUT !== addr_t[i]) begin bad++; $display("FAIL mis%0d_alu got=%0h want=%0h", i, ALU_OUT_OUT, addr_t[i]); end
      total++; if (STALL_OUT !== 1'b0) begin bad++; $display("FAIL mis%0d_stall got=%0h want=0", i, STALL_OUT); end
      @(posedge CLK); #1;
      total++; if (MISALIGNED_OUT !== 1'b0) begin bad++; $display("FAIL mis%0d_flag_clear got=%0h want=0", i, MISALIGNED_OUT); end
      total++; if (DCACHE_REQ !== 1'b0) begin bad++; $display("FAIL mis%0d_req_later got=%0h want=0", i, DCACHE_REQ); end
    end
  endtask

  task automatic test_back_to_back();
    int req_cycles;
    req_cycles = 0;
    DCACHE_READY = 1'b1;
    set_op(32'h0000_0400, 32'h0, 5'd10, 3'b010, 1'b1, 1'b0, 1'b1, 1'b1);
    @(posedge CLK); #1;
    set_op(32'h0000_0404, 32'h0, 5'd11, 3'b010, 1'b1, 1'b0, 1'b1, 1'b1);
    DCACHE_RDATA = 32'h1111_1111;
    if (DCACHE_REQ === 1'b1) req_cycles++;
    total++; if (DCACHE_ADDR !== 32'h400) begin bad++; $display("FAIL b2b_addr0 got=%0h want=400", DCACHE_ADDR); end
    total++; if (VALID_OUT !== 1'b0) begin bad++; $display("FAIL b2b_bubble got=%0h want=0", VALID_OUT); end
    @(posedge CLK); #1;
    drive_idle();
    DCACHE_RDATA = 32'h2222_2222;
    if (DCACHE_REQ === 1'b1) req_cycles++;
    total++; if (DCACHE_ADDR !== 32'h404) begin bad++; $display("FAIL b2b_addr1 got=%0h want=404", DCACHE_ADDR); end
    total++; if (VALID_OUT !== 1'b1) begin bad++; $display("FAIL b2b_valid0 got=%0h want=1", VALID_OUT); end
    total++; if (DATA_CACHE_OUT_DATA !== 32'h1111_1111) begin bad++; $display("FAIL b2b_data0 got=%0h want=11111111", DATA_CACHE_OUT_DATA); end
    total++; if (RD_ADDR_OUT !== 5'd10) begin bad++; $display("FAIL b2b_rd0 got=%0h want=a", RD_ADDR_OUT); end
    @(posedge CLK); #1;
    if (DCACHE_REQ === 1'b1) req_cycles++;
    total++; if (req_cycles != 2) begin bad++; $display("FAIL b2b_req_cycles got=%0d want=2", req_cycles); end
    total++; if (VALID_OUT !== 1'b1) begin bad++; $display("FAIL b2b_valid1 got=%0h want=1", VALID_OUT); end
    total++; if (DATA_CACHE_OUT_DATA !== 32'h2222_2222) begin bad++; $display("FAIL b2b_data1 got=%0h want=22222222", DATA_CACHE_OUT_DATA); end
    total++; if (RD_ADDR_OUT !== 5'd11) begin bad++; $display("FAIL b2b_rd1 got=%0h want=b", RD_ADDR_OUT); end
    @(posedge CLK); #1;
    total++; if (VALID_OUT !== 1'b0) begin bad++; $display("FAIL b2b_valid_end got=%0h want=0", VALID_OUT); end
    DCACHE_READY = 1'b0;
  endtask

  task automatic test_reset_mid_access();
    DCACHE_READY = 1'b0;
    set_op(32'h0000_0500, 32'h0, 5'd12, 3'b010, 1'b1, 1'b0, 1'b1, 1'b1);
    @(posedge CLK); #1;
    drive_idle();
    @(posedge CLK); #1;
    total++; if (DCACHE_REQ !== 1'b1) begin bad++; $display("FAIL rmid_req_before got=%0h want=1", DCACHE_REQ); end
    #2 RST = 1'b1;
    #1;
    total++; if (DCACHE_REQ !== 1'b0) begin bad++; $display("FAIL rmid_req got=%0h want=0", DCACHE_REQ); end
    total++; if (STALL_OUT !== 1'b0) begin bad++; $display("FAIL rmid_stall got=%0h want=0", STALL_OUT); end
    total++; if (VALID_OUT !== 1'b0) begin bad++; $display("FAIL rmid_valid got=%0h want=0", VALID_OUT); end
    @(posedge CLK); #1;
    RST = 1'b0;
    set_op(32'h0000_0102, 32'h0, 5'd13, 3'b001, 1'b1, 1'b0, 1'b1, 1'b1);
    DCACHE_READY = 1'b1; DCACHE_RDATA = 32'h8001_0000;
    @(posedge CLK); #1;
    drive_idle();
    total++; if (DCACHE_REQ !== 1'b1) begin bad++; $display("FAIL rmid_next_req got=%0h want=1", DCACHE_REQ); end
    @(posedge CLK); #1;
    total++; if (VALID_OUT !== 1'b1) begin bad++; $display("FAIL rmid_next_valid got=%0h want=1", VALID_OUT); end
    total++; if (DATA_CACHE_OUT_DATA !== 32'hFFFF_8001) begin bad++; $display("FAIL rmid_next_data got=%0h want=ffff8001", DATA_CACHE_OUT_DATA); end
    total++; if (RD_ADDR_OUT !== 5'd13) begin bad++; $display("FAIL rmid_next_rd got=%0h want=d", RD_ADDR_OUT); end
    DCACHE_READY = 1'b0;
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_misaligned();
    test_back_to_back();
    test_reset_mid_access();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
